// File: rtl/core_clock_sequencer_pkg.sv
// Shared constants for the core clock sequencer:
// run-state encodings and parameter defaults.
package core_clock_sequencer_pkg;

  localparam logic [1:0] ST_RESET_HOLD = 2'd0;
  localparam logic [1:0] ST_RUN        = 2'd1;
  localparam logic [1:0] ST_HALT       = 2'd2;
  localparam logic [1:0] ST_STEP       = 2'd3;

  localparam int DEBOUNCE_DEFAULT   = 1000000;
  localparam int RESET_HOLD_DEFAULT = 16;

  localparam int DIV_W  = 5;
  localparam int TICK_W = 32;

endpackage

// File: rtl/core_clock_sequencer_debounce.sv
// Button conditioner: 2-FF synchronizer, stability
// counter and a one-cycle pulse on each accepted press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    // Count only while the synced input disagrees with the accepted level
    if (s2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/core_clock_sequencer.sv
// Core clock sequencer: PLL-gated reset hold, divided
// core tick, run/halt/single-step control with breakpoints.
module core_clock_sequencer
  import core_clock_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_DEFAULT,
  parameter int RESET_HOLD_CYCLES = RESET_HOLD_DEFAULT
) (
  input  logic              clock_100mhz,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic              clock_mode_button,
  input  logic              manual_clock_button,
  input  logic [DIV_W-1:0]  clock_divisor,
  input  logic              hard_breakpoint,
  input  logic              soft_breakpoint,
  input  logic              soft_break_enable,
  output logic              core_clock_enable,
  output logic              core_reset,
  output logic [1:0]        run_state,
  output logic              halted,
  output logic [TICK_W-1:0] tick_count
);

  localparam int LW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(RESET_HOLD_CYCLES - 1);

  logic              mode_press, manual_press;
  logic              lock_s1_q, lock_s2_q;
  logic [1:0]        state_q, state_d;
  logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              en_q, en_d;
  logic              core_reset_q;
  logic              halted_q;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              halt_req;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clock_100mhz),
    .rst   (reset),
    .btn   (clock_mode_button),
    .press (mode_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_manual_db (
    .clk   (clock_100mhz),
    .rst   (reset),
    .btn   (manual_clock_button),
    .press (manual_press)
  );

  assign halt_req = mode_press | hard_breakpoint |
                    (soft_breakpoint & soft_break_enable);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    div_cnt_d  = div_cnt_q;
    en_d       = 1'b0;
    if (!lock_s2_q) begin
      state_d    = ST_RESET_HOLD;
      lock_cnt_d = '0;
      div_cnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_RESET_HOLD: begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_d    = ST_RUN;
            lock_cnt_d = '0;
            div_cnt_d  = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          // >= so a divisor lowered below the count wraps at once
          if (div_cnt_q >= clock_divisor) begin
            en_d      = 1'b1;
            div_cnt_d = '0;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
          if (halt_req) state_d = ST_HALT;
        end
        ST_HALT: begin
          if (mode_press) begin
            state_d   = ST_RUN;
            div_cnt_d = '0;
          end else if (manual_press) begin
            state_d = ST_STEP;
            en_d    = 1'b1;
          end
        end
        ST_STEP: state_d = ST_HALT;
        default: state_d = ST_RESET_HOLD;
      endcase
    end
    if (state_d == ST_RESET_HOLD) tick_d = '0;
    else tick_d = tick_q + {{(TICK_W-1){1'b0}}, en_d};
  end

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      lock_s1_q    <= 1'b0;
      lock_s2_q    <= 1'b0;
      state_q      <= ST_RESET_HOLD;
      lock_cnt_q   <= '0;
      div_cnt_q    <= '0;
      en_q         <= 1'b0;
      core_reset_q <= 1'b1;
      halted_q     <= 1'b0;
      tick_q       <= '0;
    end else begin
      lock_s1_q    <= pll_locked;
      lock_s2_q    <= lock_s1_q;
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      div_cnt_q    <= div_cnt_d;
      en_q         <= en_d;
      core_reset_q <= (state_d == ST_RESET_HOLD);
      halted_q     <= (state_d == ST_HALT);
      tick_q       <= tick_d;
    end
  end

  assign core_clock_enable = en_q;
  assign core_reset        = core_reset_q;
  assign run_state         = state_q;
  assign halted            = halted_q;
  assign tick_count        = tick_q;

endmodule

// File: tb/tb_core_clock_sequencer.sv
// Directed bench for core_clock_sequencer with
// DEBOUNCE_CYCLES=4 and RESET_HOLD_CYCLES=16.
module tb_core_clock_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pll;
  logic        mode_btn;
  logic        man_btn;
  logic [4:0]  div;
  logic        hb;
  logic        sb;
  logic        sbe;
  logic        en;
  logic        core_rst;
  logic [1:0]  rs;
  logic        halted;
  logic [31:0] tick;

  int passed = 0;
  int total  = 0;
  int en_seen = 0;

  core_clock_sequencer #(
    .DEBOUNCE_CYCLES   (4),
    .RESET_HOLD_CYCLES (16)
  ) dut (
    .clock_100mhz        (clk),
    .reset               (rst),
    .pll_locked          (pll),
    .clock_mode_button   (mode_btn),
    .manual_clock_button (man_btn),
    .clock_divisor       (div),
    .hard_breakpoint     (hb),
    .soft_breakpoint     (sb),
    .soft_break_enable   (sbe),
    .core_clock_enable   (en),
    .core_reset          (core_rst),
    .run_state           (rs),
    .halted              (halted),
    .tick_count          (tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) en_seen <= en_seen + int'(en);

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_en();
    int k;
    k = 0;
    while (en !== 1'b1 && k < 40) begin
      step(1);
      k++;
    end
    total++;
    if (en !== 1'b1)
      $display("FAIL wait_en: en=%b after %0d cycles, need 1", en, k);
    else passed++;
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    step(10);
    mode_btn = 1'b0;
    step(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll = 1'b1;
    step(3);
    total++;
    if (rs !== 2'd0) $display("FAIL rst_state: got %0d need 0", rs);
    else passed++;
    total++;
    if (core_rst !== 1'b1 || en !== 1'b0 || halted !== 1'b0)
      $display("FAIL rst_outs: core_reset=%b en=%b halted=%b need 1 0 0",
               core_rst, en, halted);
    else passed++;
    total++;
    if (tick !== 32'd0) $display("FAIL rst_tick: got %0d need 0", tick);
    else passed++;
    rst = 1'b0;
    step(17);
    total++;
    if (rs !== 2'd0 || core_rst !== 1'b1)
      $display("FAIL lock_early: state=%0d core_reset=%b need 0 1",
               rs, core_rst);
    else passed++;
    step(1);
    total++;
    if (rs !== 2'd1 || core_rst !== 1'b0)
      $display("FAIL lock_release: state=%0d core_reset=%b need 1 0",
               rs, core_rst);
    else passed++;
  endtask

  task automatic test_divider();
    logic [31:0] t0;
    logic [3:0]  pat;
    t0 = tick;
    step(40);
    total++;
    if (tick - t0 !== 32'd10)
      $display("FAIL div3_40: got %0d ticks need 10", tick - t0);
    else passed++;
    wait_en();
    for (int i = 0; i < 4; i++) begin
      step(1);
      pat[i] = en;
    end
    total++;
    if (pat !== 4'b1000)
      $display("FAIL div3_period: pattern=%b need 1000", pat);
    else passed++;
    div = 5'd0;
    step(2);
    t0 = tick;
    step(5);
    total++;
    if (tick - t0 !== 32'd5)
      $display("FAIL div0: got %0d ticks need 5", tick - t0);
    else passed++;
    div = 5'd3;
    step(5);
  endtask

  task automatic test_buttons();
    logic [31:0] t0;
    int e0;
    mode_btn = 1'b1;
    step(2);
    mode_btn = 1'b0;
    step(10);
    total++;
    if (rs !== 2'd1) $display("FAIL glitch: state=%0d need 1", rs);
    else passed++;
    press_mode();
    total++;
    if (rs !== 2'd2 || halted !== 1'b1)
      $display("FAIL mode_halt: state=%0d halted=%b need 2 1", rs, halted);
    else passed++;
    step(5);
    t0 = tick;
    e0 = en_seen;
    man_btn = 1'b1;
    step(10);
    man_btn = 1'b0;
    step(10);
    total++;
    if (tick !== t0 + 32'd1 || en_seen - e0 != 1)
      $display("FAIL step: tick=%0d en=%0d need %0d 1",
               tick, en_seen - e0, t0 + 32'd1);
    else passed++;
    total++;
    if (rs !== 2'd2 || halted !== 1'b1)
      $display("FAIL step_ret: state=%0d halted=%b need 2 1", rs, halted);
    else passed++;
  endtask

  task automatic test_breakpoints();
    logic [31:0] t0;
    press_mode();
    step(3);
    total++;
    if (rs !== 2'd1) $display("FAIL resume: state=%0d need 1", rs);
    else passed++;
    sbe = 1'b0;
    sb  = 1'b1;
    step(6);
    sb = 1'b0;
    total++;
    if (rs !== 2'd1) $display("FAIL soft_masked: state=%0d need 1", rs);
    else passed++;
    wait_en();
    t0 = tick;
    step(3);
    hb = 1'b1;
    step(1);
    hb = 1'b0;
    total++;
    if (en !== 1'b1 || rs !== 2'd2 || tick !== t0 + 32'd1)
      $display("FAIL hard_wrap: en=%b state=%0d tick=%0d need 1 2 %0d",
               en, rs, tick, t0 + 32'd1);
    else passed++;
    step(1);
    total++;
    if (en !== 1'b0 || halted !== 1'b1)
      $display("FAIL hard_after: en=%b halted=%b need 0 1", en, halted);
    else passed++;
    press_mode();
    step(2);
    sbe = 1'b1;
    sb  = 1'b1;
    hb  = 1'b1;
    step(1);
    sb = 1'b0;
    hb = 1'b0;
    sbe = 1'b0;
    step(5);
    total++;
    if (rs !== 2'd2) $display("FAIL multi_halt: state=%0d need 2", rs);
    else passed++;
    mode_btn = 1'b1;
    man_btn  = 1'b1;
    step(10);
    mode_btn = 1'b0;
    man_btn  = 1'b0;
    step(3);
    total++;
    if (rs !== 2'd1) $display("FAIL mode_wins: state=%0d need 1", rs);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    div = 5'd0;
    step(3);
    total++;
    if (en !== 1'b1) $display("FAIL pre_rst_en: en=%b need 1", en);
    else passed++;
    rst = 1'b1;
    step(1);
    total++;
    if (en !== 1'b0 || rs !== 2'd0 || core_rst !== 1'b1 || tick !== 0)
      $display("FAIL rst_mid: en=%b st=%0d cr=%b tick=%0d need 0 0 1 0",
               en, rs, core_rst, tick);
    else passed++;
    rst = 1'b0;
    div = 5'd3;
    step(18);
    total++;
    if (rs !== 2'd1) $display("FAIL rst_relock: state=%0d need 1", rs);
    else passed++;
  endtask

  task automatic test_pll_drop();
    step(10);
    pll = 1'b0;
    step(3);
    total++;
    if (core_rst !== 1'b1 || tick !== 32'd0 || rs !== 2'd0)
      $display("FAIL pll_drop: cr=%b tick=%0d st=%0d need 1 0 0",
               core_rst, tick, rs);
    else passed++;
    step(5);
    pll = 1'b1;
    step(17);
    total++;
    if (rs !== 2'd0) $display("FAIL relock_early: state=%0d need 0", rs);
    else passed++;
    step(1);
    total++;
    if (rs !== 2'd1 || core_rst !== 1'b0)
      $display("FAIL relock: state=%0d cr=%b need 1 0", rs, core_rst);
    else passed++;
  endtask

  initial begin
    rst      = 1'b1;
    pll      = 1'b1;
    mode_btn = 1'b0;
    man_btn  = 1'b0;
    div      = 5'd3;
    hb       = 1'b0;
    sb       = 1'b0;
    sbe      = 1'b0;
    test_reset();
    test_divider();
    test_buttons();
    test_breakpoints();
    test_reset_mid_run();
    test_pll_drop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
